// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register for a multi-issue core: per-lane valid, flush,
// zero-register suppression, youngest-writer-wins conflict resolution and retire counting.
module mem_wb_pipe #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STAGE  = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [5:0]                stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          mem_valid,
  input  logic [LANES*ADDR_W-1:0]   mem_wd,
  input  logic [LANES*DATA_W-1:0]   mem_wdata,
  input  logic [LANES-1:0]          mem_wreg,
  input  logic                      mem_whilo,
  input  logic [DATA_W-1:0]         mem_hi,
  input  logic [DATA_W-1:0]         mem_lo,
  output logic [LANES-1:0]          wb_valid,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [LANES-1:0]          wb_wreg,
  output logic                      wb_whilo,
  output logic [DATA_W-1:0]         wb_hi,
  output logic [DATA_W-1:0]         wb_lo,
  output logic [CNT_W-1:0]          retire_cnt
);

  logic             stall_here;
  logic             stall_next;
  logic             bubble;
  logic [LANES-1:0] wreg_next;
  logic [CNT_W-1:0] valid_cnt;

  assign stall_here = stall[STAGE];
  assign stall_next = stall[STAGE+1];
  assign bubble     = stall_here & ~stall_next;

  // A lane writes only if valid, enabled, non-zero dest, and no younger valid writer hits the same dest.
  always_comb begin
    wreg_next = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wreg_next[i] = mem_valid[i] & mem_wreg[i] & (mem_wd[i*ADDR_W +: ADDR_W] != '0);
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (mem_valid[j] && mem_wreg[j] &&
            (mem_wd[j*ADDR_W +: ADDR_W] == mem_wd[i*ADDR_W +: ADDR_W])) begin
          wreg_next[i] = 1'b0;
        end
      end
    end
  end

  // Number of valid lanes in the incoming bundle.
  always_comb begin
    valid_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      valid_cnt = valid_cnt + CNT_W'(mem_valid[i]);
    end
  end

  // Flush beats every stall pattern; hold leaves all state untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid   <= '0;
      wb_wd      <= '0;
      wb_wdata   <= '0;
      wb_wreg    <= '0;
      wb_whilo   <= 1'b0;
      wb_hi      <= '0;
      wb_lo      <= '0;
      retire_cnt <= '0;
    end else if (flush || bubble) begin
      wb_valid   <= '0;
      wb_wd      <= '0;
      wb_wdata   <= '0;
      wb_wreg    <= '0;
      wb_whilo   <= 1'b0;
      wb_hi      <= '0;
      wb_lo      <= '0;
    end else if (!stall_here) begin
      wb_valid   <= mem_valid;
      wb_wd      <= mem_wd;
      wb_wdata   <= mem_wdata;
      wb_wreg    <= wreg_next;
      wb_whilo   <= mem_whilo & (|mem_valid);
      wb_hi      <= mem_hi;
      wb_lo      <= mem_lo;
      retire_cnt <= retire_cnt + valid_cnt;
    end
  end

endmodule
